// File: rtl/nn_pkg.sv
// Shared definitions for the nearest-neighbour frame reader.
// Build option: NN_RESAMP_ROUND_EN (round half-up instead of truncate,
// used by nn_addr_gen).
package nn_pkg;

   localparam int          NN_FRAC_W = 20;
   localparam logic [31:0] NN_ONE    = 32'h100000;
   localparam int          NN_SRC_AW = 11;
   localparam int          NN_IDX_W  = 9;
   // 9 index bits times a 32-bit ratio never exceeds 41 bits.
   localparam int          NN_ACC_W  = 41;
   localparam int          NN_INT_W  = NN_ACC_W - NN_FRAC_W;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } nn_state_e;

   // Clamp the integer part of the accumulator onto the source address range.
   function automatic logic [NN_SRC_AW-1:0] nn_sat_addr(input logic [NN_INT_W-1:0] whole);
      if (|whole[NN_INT_W-1:NN_SRC_AW]) begin
         return {NN_SRC_AW{1'b1}};
      end
      return whole[NN_SRC_AW-1:0];
   endfunction

endpackage

// File: rtl/nn_frame_reader_if.sv
// Bus bundle between control logic, the two frame BRAMs and nn_frame_reader.
// Handshake: start is a one-cycle request with no ready line; it is taken only
// when the engine is idle (busy low and done low), otherwise it is dropped.
// src_data must be valid one cycle after src_addr; dst_* write when dst_we=1.
interface nn_frame_reader_if #(
   parameter int DATA_W = 16
);
   import nn_pkg::*;

   logic                 start;
   logic [31:0]          shift;
   logic [NN_SRC_AW-1:0] src_addr;
   logic [DATA_W-1:0]    src_data;
   logic                 dst_we;
   logic [NN_IDX_W-1:0]  dst_addr;
   logic [DATA_W-1:0]    dst_data;
   logic                 busy;
   logic                 done;
   nn_state_e            dbg_state;

   modport master (
      output start, shift, src_data,
      input  src_addr, dst_we, dst_addr, dst_data, busy, done, dbg_state
   );

   modport slave (
      input  start, shift, src_data,
      output src_addr, dst_we, dst_addr, dst_data, busy, done, dbg_state
   );

endinterface

// File: rtl/nn_addr_gen.sv
// Running-accumulator replacement for index*shift, with round/saturate.
// acc_q always holds the accumulator of the NEXT sample, so the registered
// address for sample 0 can be presented in the cycle right after start.
// Build option: NN_RESAMP_ROUND_EN adds half a sample before the shift.
module nn_addr_gen
   import nn_pkg::*;
(
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 clear,
   input  logic                 step,
   input  logic [31:0]          shift,
   output logic [NN_SRC_AW-1:0] addr
);

   logic [NN_ACC_W-1:0]  acc_q, acc_d;
   logic [NN_SRC_AW-1:0] addr_q, addr_d;
   logic [NN_INT_W-1:0]  whole;

`ifdef NN_RESAMP_ROUND_EN
   localparam logic [NN_ACC_W-1:0] HALF = NN_ACC_W'(1) << (NN_FRAC_W - 1);
`endif

   // Next accumulator and next address from clear/step.
   always_comb begin
      acc_d  = acc_q;
      addr_d = addr_q;
`ifdef NN_RESAMP_ROUND_EN
      whole  = NN_INT_W'((acc_q + HALF) >> NN_FRAC_W);
`else
      whole  = acc_q[NN_ACC_W-1:NN_FRAC_W];
`endif
      if (clear) begin
         acc_d  = {{(NN_ACC_W-32){1'b0}}, shift};
         addr_d = '0;
      end else if (step) begin
         acc_d  = acc_q + {{(NN_ACC_W-32){1'b0}}, shift};
         addr_d = nn_sat_addr(whole);
      end
   end

   // Accumulator and address registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         acc_q  <= '0;
         addr_q <= '0;
      end else begin
         acc_q  <= acc_d;
         addr_q <= addr_d;
      end
   end

   assign addr = addr_q;

endmodule

// File: rtl/nn_frame_reader.sv
// Nearest-neighbour frame resampler: walks output index 0..FRAME_LEN-1,
// reads source sample index*shift, writes it to the output frame.
// Build option: NN_RESAMP_ROUND_EN (see nn_addr_gen).
module nn_frame_reader
   import nn_pkg::*;
#(
   parameter int FRAME_LEN = 512,
   parameter int DATA_W    = 16
) (
   input  logic               clock,
   input  logic               reset,
   nn_frame_reader_if.slave   bus
);

   nn_state_e            state_q, state_d;
   logic [NN_IDX_W-1:0]  idx_q, idx_d;
   logic [31:0]          shift_q, shift_d;
   logic                 we_q;
   logic [NN_IDX_W-1:0]  waddr_q;
   logic                 clear, step, busy, done, last_idx;
   logic [31:0]          gen_shift;

   assign last_idx = (idx_q == NN_IDX_W'(FRAME_LEN - 1));

   // FSM next state and control strobes.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      clear   = 1'b0;
      step    = 1'b0;
      busy    = 1'b0;
      done    = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d = RUN;
               clear   = 1'b1;
               idx_d   = '0;
               shift_d = bus.shift;
            end
         end
         RUN: begin
            busy  = 1'b1;
            idx_d = idx_q + 1'b1;
            if (last_idx) begin
               state_d = FLUSH;
            end else begin
               step = 1'b1;
            end
         end
         FLUSH: begin
            busy    = 1'b1;
            state_d = DONE;
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM state, index counter and latched ratio.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         idx_q   <= '0;
         shift_q <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
      end
   end

   // One-stage write pipeline aligned with the BRAM read latency.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         we_q    <= 1'b0;
         waddr_q <= '0;
      end else begin
         we_q    <= (state_q == RUN);
         waddr_q <= idx_q;
      end
   end

   // The live ratio seeds the accumulator on the accept cycle only.
   assign gen_shift = clear ? bus.shift : shift_q;

   nn_addr_gen u_addr_gen (
      .clock (clock),
      .reset (reset),
      .clear (clear),
      .step  (step),
      .shift (gen_shift),
      .addr  (bus.src_addr)
   );

   assign bus.dst_we    = we_q;
   assign bus.dst_addr  = waddr_q;
   assign bus.dst_data  = DATA_W'(bus.src_data);
   assign bus.busy      = busy;
   assign bus.done      = done;
   assign bus.dbg_state = state_q;

endmodule
